// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier.
// Holds the operand width, the op-code encoding and the FSM state set,
// plus helpers that say which operands are treated as signed for each op.
package mul_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,  // low half, sign-agnostic
    OP_MULH   = 2'b01,  // signed x signed, high half
    OP_MULHSU = 2'b10,  // signed rs1 x unsigned rs2, high half
    OP_MULHU  = 2'b11   // unsigned x unsigned, high half
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_MUL,
    S_FIX_LO,
    S_FIX_HI,
    S_DONE
  } state_e;

  function automatic logic rs1_signed(input op_e op);
    return op != OP_MULHU;
  endfunction

  function automatic logic rs2_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/CLA32bit.sv
// 32-bit two-level carry-lookahead adder.
// Ports: a, b  - addends; cin - carry in; sum - a+b+cin (low 32 bits);
//        cout  - carry out of bit 31.
// Bits are grouped in nibbles: each nibble forms group generate/propagate,
// group carries are resolved from those, then in-nibble carries are expanded.
module CLA32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;

    for (int unsigned k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end

    gc[0] = cin;
    for (int unsigned k = 0; k < 8; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end

    for (int unsigned k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[32] = gc[8];

    sum  = p ^ c[31:0];
    cout = c[32];
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential 32x32 multiplier (MUL/MULH/MULHSU/MULHU) built around a single
// shared carry-lookahead adder. Operands are converted to magnitudes, a
// 32-step shift-add produces the unsigned product, and a two-step negate
// restores the sign. Fixed 37-cycle latency from start to o_done.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - asynchronous active-high reset
//   i_start  - request pulse, only honoured in IDLE
//   i_op     - operation code (see mul_pkg::op_e)
//   i_rs1    - multiplicand
//   i_rs2    - multiplier
//   o_busy   - operation in progress, through the DONE cycle
//   o_done   - one-cycle completion pulse, o_result valid with it
//   o_result - selected product half, held afterwards
module seq_multiplier #(
  parameter int unsigned XLEN = mul_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  import mul_pkg::*;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;        // rs1, then |rs1|
  logic [2*XLEN-1:0] p_q, p_d;        // low half holds rs2 until ABS_B
  logic [4:0]        cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              carry_q, carry_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic [XLEN-1:0]   add_a, add_b, add_sum;
  logic              add_cin, add_cout;
  logic [XLEN-1:0]   res_sel;
  op_e               op_in;

  CLA32bit u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    res_d   = res_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    op_in   = op_e'(i_op);
    res_sel = (op_q == OP_MUL) ? p_q[XLEN-1:0] : p_q[2*XLEN-1:XLEN];

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          op_d    = op_in;
          a_d     = i_rs1;
          p_d     = {{XLEN{1'b0}}, i_rs2};
          cnt_d   = '0;
          carry_d = 1'b0;
          neg_d   = (rs1_signed(op_in) & i_rs1[XLEN-1])
                  ^ (rs2_signed(op_in) & i_rs2[XLEN-1]);
          state_d = S_ABS_A;
        end
      end
      S_ABS_A: begin
        // Negation as ~x+1; 0x80000000 maps to itself and is used unsigned.
        if (rs1_signed(op_q) && a_q[XLEN-1]) begin
          add_a   = ~a_q;
          add_cin = 1'b1;
        end else begin
          add_a   = a_q;
        end
        a_d     = add_sum;
        state_d = S_ABS_B;
      end
      S_ABS_B: begin
        if (rs2_signed(op_q) && p_q[XLEN-1]) begin
          add_a   = ~p_q[XLEN-1:0];
          add_cin = 1'b1;
        end else begin
          add_a   = p_q[XLEN-1:0];
        end
        p_d     = {{XLEN{1'b0}}, add_sum};
        state_d = S_MUL;
      end
      S_MUL: begin
        add_a = p_q[2*XLEN-1:XLEN];
        add_b = a_q;
        if (p_q[0]) begin
          p_d = {add_cout, add_sum, p_q[XLEN-1:1]};
        end else begin
          p_d = {1'b0, p_q[2*XLEN-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX_LO;
        end
      end
      S_FIX_LO: begin
        // Two's-complement negate of the 64-bit product split over two
        // adder passes; the low-half carry feeds the high half.
        if (neg_q) begin
          add_a            = ~p_q[XLEN-1:0];
          add_cin          = 1'b1;
          p_d[XLEN-1:0]    = add_sum;
          carry_d          = add_cout;
        end else begin
          carry_d          = 1'b0;
        end
        state_d = S_FIX_HI;
      end
      S_FIX_HI: begin
        if (neg_q) begin
          add_a                 = ~p_q[2*XLEN-1:XLEN];
          add_cin               = carry_q;
          p_d[2*XLEN-1:XLEN]    = add_sum;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        res_d   = res_sel;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      res_q   <= res_d;
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_DONE);
  // The result is presented combinationally in DONE and registered for hold.
  assign o_result = (state_q == S_DONE) ? res_sel : res_q;

endmodule
